// File: rtl/inst_sram_responder.sv
// -----------------------------------------------------------------------------
// inst_sram_responder
//
// Responder end of the instruction-SRAM interface driven by the fetch stage.
// The storage is a word-organised synchronous RAM with:
//   - one-cycle read latency,
//   - byte-lane writes,
//   - read data that is held while the port is idle,
//   - out-of-range detection,
//   - a side loader port used to preload a boot or bench image,
//   - read and write access counters.
//
// Ports
//   clk              clock
//   reset            synchronous active-high reset
//   inst_sram_en     access request this cycle (always accepted)
//   inst_sram_we     byte-lane write enables; 0 = read
//   inst_sram_addr   byte address; [1:0] ignored
//   inst_sram_wdata  write data, lane i = bits [8i+7:8i]
//   inst_sram_rdata  read data, valid the cycle after an accepted access
//   ld_en            loader full-word write strobe
//   ld_addr          loader byte address; [1:0] ignored
//   ld_data          loader write data
//   oor_err          sticky: some access or load fell outside the array
//   oor_addr         address of the first out-of-range access
//   rd_cnt           accepted read count (wraps)
//   wr_cnt           accepted port-write count (wraps)
// -----------------------------------------------------------------------------
module inst_sram_responder #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter logic [31:0] BASE_ADDR  = 32'h1C00_0000,  // must be word aligned
    parameter bit          READ_FIRST = 1'b1,
    parameter logic [31:0] OOR_DATA   = 32'h0340_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data,
    output logic        oor_err,
    output logic [31:0] oor_addr,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    // NOTE: the array has no reset; its contents survive reset, and clearing
    // it would prevent mapping it onto an SRAM macro.
    logic [31:0] mem [DEPTH];

    // Address decode is done on word offsets. Because BASE_ADDR is word
    // aligned, addr[31:2] - BASE[31:2] equals (addr - BASE)[31:2].
    logic [29:0]           port_woff, ld_woff;
    logic                  port_in_range, ld_in_range;
    logic [ADDR_WIDTH-1:0] port_idx, ld_idx;

    assign port_woff     = inst_sram_addr[31:2] - BASE_ADDR[31:2];
    assign ld_woff       = ld_addr[31:2] - BASE_ADDR[31:2];
    assign port_in_range = (port_woff >> ADDR_WIDTH) == '0;
    assign ld_in_range   = (ld_woff >> ADDR_WIDTH) == '0;
    assign port_idx      = port_woff[ADDR_WIDTH-1:0];
    assign ld_idx        = ld_woff[ADDR_WIDTH-1:0];

    logic port_rd, port_wr, port_oor, ld_oor;
    logic port_wr_ok, ld_ok, ld_hit;

    assign port_rd    = inst_sram_en && (inst_sram_we == 4'b0000);
    assign port_wr    = inst_sram_en && (inst_sram_we != 4'b0000);
    assign port_oor   = inst_sram_en && !port_in_range;
    assign ld_oor     = ld_en && !ld_in_range;
    assign port_wr_ok = port_wr && port_in_range && !reset;
    assign ld_ok      = ld_en && ld_in_range && !reset;
    // A loader write to the addressed word overrides the port's view of it.
    assign ld_hit     = ld_ok && (ld_idx == port_idx);

    // Old word, byte-merged port write, and the word as it will be after the
    // edge (the loader wins fully over a port write to the same word).
    logic [31:0] old_word, merged_word, new_word;

    always_comb begin
        old_word    = mem[port_idx];
        merged_word = old_word;
        for (int i = 0; i < 4; i++) begin
            if (inst_sram_we[i]) merged_word[8*i +: 8] = inst_sram_wdata[8*i +: 8];
        end
        new_word = ld_hit ? ld_data : merged_word;
    end

    always_ff @(posedge clk) begin
        if (port_wr_ok) mem[port_idx] <= merged_word;
        // Placed after the port write so the loader takes the word on a clash.
        if (ld_ok) mem[ld_idx] <= ld_data;
    end

    logic [31:0] rdata_q, rdata_d;
    logic        oor_err_q, oor_err_d;
    logic [31:0] oor_addr_q, oor_addr_d;
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;

    // NOTE: every _d starts from its hold value so no path leaves a variable
    // unassigned, which would infer a latch.
    always_comb begin
        rdata_d    = rdata_q;
        oor_err_d  = oor_err_q;
        oor_addr_d = oor_addr_q;
        rd_cnt_d   = rd_cnt_q;
        wr_cnt_d   = wr_cnt_q;

        if (reset) begin
            rdata_d    = '0;
            oor_err_d  = 1'b0;
            oor_addr_d = '0;
            rd_cnt_d   = '0;
            wr_cnt_d   = '0;
        end else begin
            if (inst_sram_en) begin
                if (!port_in_range) rdata_d = OOR_DATA;
                else                rdata_d = READ_FIRST ? old_word : new_word;
            end
            if (port_rd) rd_cnt_d = rd_cnt_q + 32'd1;
            if (port_wr) wr_cnt_d = wr_cnt_q + 32'd1;
            // Only the first offender is recorded; the port takes priority.
            if (!oor_err_q) begin
                if (port_oor)    oor_addr_d = inst_sram_addr;
                else if (ld_oor) oor_addr_d = ld_addr;
            end
            if (port_oor || ld_oor) oor_err_d = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        rdata_q    <= rdata_d;
        oor_err_q  <= oor_err_d;
        oor_addr_q <= oor_addr_d;
        rd_cnt_q   <= rd_cnt_d;
        wr_cnt_q   <= wr_cnt_d;
    end

    assign inst_sram_rdata = rdata_q;
    assign oor_err         = oor_err_q;
    assign oor_addr        = oor_addr_q;
    assign rd_cnt          = rd_cnt_q;
    assign wr_cnt          = wr_cnt_q;

endmodule
